// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches/jumps, issues a held fetch redirect plus one-cycle pipeline flushes.
// Latency: redirect/flush/misalign registered, visible in the cycle after the resolving edge.
// Backpressure: redirect_valid held while if_stall=1; EX is stalled and new branches ignored until accepted.
module branch_resolve_unit #(
    parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [2:0]  br_op,
    input  logic        zero,
    input  logic        sign,
    input  logic [31:0] br_target,
    input  logic        if_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        ex_stall,
    output logic        misalign,
    output logic [15:0] br_cnt,
    output logic [15:0] taken_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BLEZ = 3'b011;
    localparam logic [2:0] OP_BGTZ = 3'b100;
    localparam logic [2:0] OP_JUMP = 3'b101;

    state_t state, state_nxt;
    logic   is_br;
    logic   cond_taken;
    logic   resolve;
    logic   take;
    logic   flush_q;
    logic   misalign_q;

    always_comb begin
        is_br      = 1'b1;
        cond_taken = 1'b0;
        case (br_op)
            OP_BEQ:  cond_taken = zero;
            OP_BNE:  cond_taken = ~zero;
            OP_BLEZ: cond_taken = zero | sign;
            OP_BGTZ: cond_taken = ~zero & ~sign;
            OP_JUMP: cond_taken = 1'b1;
            default: is_br      = 1'b0;
        endcase
    end

    // Branches arriving while a redirect is pending are ignored entirely.
    assign resolve = (state == IDLE) && ex_valid && is_br;
    assign take    = resolve && cond_taken;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (take)      state_nxt = PEND;
            PEND: if (!if_stall) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc <= 32'h0;
            flush_q     <= 1'b0;
            misalign_q  <= 1'b0;
            br_cnt      <= 16'h0;
            taken_cnt   <= 16'h0;
        end else begin
            flush_q    <= take;
            misalign_q <= take && (br_target[1:0] != 2'b00);
            if (take) begin
                redirect_pc <= {br_target[31:2], 2'b00};
            end
            if (resolve && (br_cnt != CNT_MAX)) begin
                br_cnt <= br_cnt + 16'd1;
            end
            if (take && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
        end
    end

    assign redirect_valid = (state == PEND);
    assign ex_stall       = (state == PEND) && if_stall;
    assign flush_if_id    = flush_q;
    assign flush_id_ex    = flush_q;
    assign misalign       = misalign_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; counter ceiling lowered so saturation is reachable quickly.
module tb_branch_resolve_unit;

    localparam logic [15:0] SAT = 16'h0040;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [2:0]  br_op;
    logic        zero;
    logic        sign;
    logic [31:0] br_target;
    logic        if_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        ex_stall;
    logic        misalign;
    logic [15:0] br_cnt;
    logic [15:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.CNT_MAX(SAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .br_op          (br_op),
        .zero           (zero),
        .sign           (sign),
        .br_target      (br_target),
        .if_stall       (if_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .ex_stall       (ex_stall),
        .misalign       (misalign),
        .br_cnt         (br_cnt),
        .taken_cnt      (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic rv, input logic [31:0] pc, input logic fl,
                           input logic st, input logic mis, input logic [15:0] bc, input logic [15:0] tc);
        chk({tag, ".rv"},  {31'h0, redirect_valid}, {31'h0, rv});
        chk({tag, ".pc"},  redirect_pc, pc);
        chk({tag, ".fif"}, {31'h0, flush_if_id}, {31'h0, fl});
        chk({tag, ".fie"}, {31'h0, flush_id_ex}, {31'h0, fl});
        chk({tag, ".stl"}, {31'h0, ex_stall}, {31'h0, st});
        chk({tag, ".mis"}, {31'h0, misalign}, {31'h0, mis});
        chk({tag, ".bc"},  {16'h0, br_cnt}, {16'h0, bc});
        chk({tag, ".tc"},  {16'h0, taken_cnt}, {16'h0, tc});
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic z, input logic s,
                         input logic [31:0] tgt, input logic stl);
        ex_valid  = v;
        br_op     = op;
        zero      = z;
        sign      = s;
        br_target = tgt;
        if_stall  = stl;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // beq taken, accepted immediately
        drive(1'b1, 3'b001, 1'b1, 1'b0, 32'h0040_0020, 1'b0);
        tick();
        chk_all("beq", 1'b1, 32'h0040_0020, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_all("beq_acc", 1'b0, 32'h0040_0020, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1);

        // bne not taken, then blez taken on sign
        drive(1'b1, 3'b010, 1'b1, 1'b0, 32'h0000_0800, 1'b0);
        tick();
        chk_all("bne_nt", 1'b0, 32'h0040_0020, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1);
        drive(1'b1, 3'b011, 1'b0, 1'b1, 32'h0000_2000, 1'b0);
        tick();
        chk_all("blez", 1'b1, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 16'd3, 16'd2);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_all("blez_acc", 1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 16'd3, 16'd2);

        // jump held by fetch stall; a branch offered meanwhile must be ignored
        drive(1'b1, 3'b101, 1'b0, 1'b0, 32'h0000_0100, 1'b1);
        tick();
        chk_all("jmp_s1", 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 16'd4, 16'd3);
        drive(1'b1, 3'b001, 1'b1, 1'b0, 32'h0000_0200, 1'b1);
        tick();
        chk_all("jmp_s2", 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 16'd4, 16'd3);
        tick();
        chk_all("jmp_s3", 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 16'd4, 16'd3);
        if_stall = 1'b0;
        #1;
        chk("jmp_rel_stall", {31'h0, ex_stall}, 32'h0);
        tick();
        chk_all("jmp_acc", 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 16'd4, 16'd3);

        // bgtz to a misaligned target
        drive(1'b1, 3'b100, 1'b0, 1'b0, 32'h0000_1003, 1'b0);
        tick();
        chk_all("bgtz_mis", 1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b1, 16'd5, 16'd4);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_all("bgtz_acc", 1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 16'd5, 16'd4);

        // bgtz not taken on sign, then reserved opcode is not a branch
        drive(1'b1, 3'b100, 1'b0, 1'b1, 32'h0000_3000, 1'b0);
        tick();
        chk_all("bgtz_nt", 1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 16'd6, 16'd4);
        drive(1'b1, 3'b110, 1'b1, 1'b0, 32'h0000_3000, 1'b0);
        tick();
        chk_all("op110", 1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 16'd6, 16'd4);

        // back-to-back jumps: accept cycle separates them
        drive(1'b1, 3'b101, 1'b0, 1'b0, 32'h0000_0300, 1'b0);
        tick();
        chk_all("b2b_1", 1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 16'd7, 16'd5);
        br_target = 32'h0000_0304;
        tick();
        chk_all("b2b_gap", 1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 16'd7, 16'd5);
        tick();
        chk_all("b2b_2", 1'b1, 32'h0000_0304, 1'b1, 1'b0, 1'b0, 16'd8, 16'd6);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();

        // asynchronous reset while pending
        drive(1'b1, 3'b101, 1'b0, 1'b0, 32'h0000_0400, 1'b1);
        tick();
        chk("pre_rst_rv", {31'h0, redirect_valid}, 32'h1);
        ex_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        chk_all("rst_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        rst_n = 1'b1;
        drive(1'b1, 3'b001, 1'b1, 1'b0, 32'h0040_0020, 1'b0);
        tick();
        chk_all("post_rst", 1'b1, 32'h0040_0020, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();

        // saturation: 100 more jumps against a ceiling of 0x40
        drive(1'b1, 3'b101, 1'b0, 1'b0, 32'h0000_0040, 1'b0);
        for (int i = 0; i < 200; i++) begin
            tick();
        end
        drive(1'b1, 3'b010, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        chk("sat_bc", {16'h0, br_cnt}, {16'h0, SAT});
        chk("sat_tc", {16'h0, taken_cnt}, {16'h0, SAT});
        chk("sat_rv", {31'h0, redirect_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
